// File: rtl/div_pkg.sv
// Shared types and constants for the sequential radix-2 restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DEF_WIDTH = 16;
  localparam int CNT_W     = $clog2(DEF_WIDTH);
  localparam logic [DEF_WIDTH-1:0] DIV_ZERO_QUOT = {DEF_WIDTH{1'b1}};

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted partial remainder.
module div_sub_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   shifted_rem,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0] trial_s;

  // Keep the difference when it did not borrow, otherwise restore.
  always_comb begin
    trial_s = shifted_rem - {1'b0, divisor_mag};
    if (!trial_s[WIDTH]) begin
      next_rem = trial_s[WIDTH-1:0];
      q_bit    = 1'b1;
    end else begin
      next_rem = shifted_rem[WIDTH-1:0];
      q_bit    = 1'b0;
    end
  end

endmodule

// File: rtl/seq_divider_16.sv
// 16-bit multi-cycle signed/unsigned divider with valid/ready handshakes.
// Optional macro DIV_EARLY_OUT_EN finishes in one cycle when |dividend| < |divisor|.
module seq_divider_16
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_t       state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] rem_r, dvd_r, dmag_r;
  logic             q_neg_r, r_neg_r;
  logic [WIDTH-1:0] quotient_r, remainder_r;
  logic             dbz_r, in_ready_r, out_valid_r, busy_r;

  logic [WIDTH-1:0] a_mag_s, b_mag_s, step_rem_s, q_mag_s;
  logic             step_q_s, accept_s, zero_div_s, early_s, last_s;

  assign a_mag_s    = (signed_op && dividend[WIDTH-1]) ? (~dividend + ONE) : dividend;
  assign b_mag_s    = (signed_op && divisor[WIDTH-1])  ? (~divisor + ONE)  : divisor;
  assign accept_s   = in_valid && (state_r == IDLE);
  assign zero_div_s = (divisor == ZERO);
  assign last_s     = (cnt_r == LAST_CNT);
  assign q_mag_s    = {dvd_r[WIDTH-2:0], step_q_s};
`ifdef DIV_EARLY_OUT_EN
  assign early_s    = !zero_div_s && (a_mag_s < b_mag_s);
`else
  assign early_s    = 1'b0;
`endif

  div_sub_step #(.WIDTH(WIDTH)) u_step (
    .shifted_rem (({rem_r, dvd_r[WIDTH-1]})),
    .divisor_mag (dmag_r),
    .next_rem    (step_rem_s),
    .q_bit       (step_q_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          if (zero_div_s || early_s) state_next_s = DONE;
          else                       state_next_s = CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (last_s) state_next_s = DONE;
        else        state_next_s = CALC;
      end
      DONE: begin
        if (out_ready) state_next_s = IDLE;
        else           state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Handshake flags registered from the upcoming state so they change glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= (state_next_s == IDLE);
      out_valid_r <= (state_next_s == DONE);
      busy_r      <= (state_next_s != IDLE);
    end
  end

  // Datapath: operand capture, iteration, sign correction and result hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r       <= '0;
      rem_r       <= '0;
      dvd_r       <= '0;
      dmag_r      <= '0;
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && zero_div_s) begin
            quotient_r  <= DIV_ZERO_QUOT;
            remainder_r <= dividend;
            dbz_r       <= 1'b1;
          end else if (accept_s && early_s) begin
            quotient_r  <= ZERO;
            remainder_r <= dividend;
            dbz_r       <= 1'b0;
          end else if (accept_s) begin
            rem_r   <= ZERO;
            dvd_r   <= a_mag_s;
            dmag_r  <= b_mag_s;
            q_neg_r <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_r <= signed_op && dividend[WIDTH-1];
            cnt_r   <= '0;
            dbz_r   <= 1'b0;
          end
        end
        CALC: begin
          rem_r <= step_rem_s;
          dvd_r <= q_mag_s;
          cnt_r <= cnt_r + 1'b1;
          if (last_s) begin
            // -0x8000 wraps to itself, so signed overflow falls out naturally.
            quotient_r  <= q_neg_r ? (~q_mag_s + ONE) : q_mag_s;
            remainder_r <= r_neg_r ? (~step_rem_s + ONE) : step_rem_s;
          end
        end
        DONE: begin
          if (out_ready) dbz_r <= 1'b0;
        end
        default: begin
          dbz_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign busy        = busy_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider_16.sv
// Directed self-checking bench for seq_divider_16 (both DIV_EARLY_OUT_EN builds).
module tb_seq_divider_16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = 16'h0000;
  logic [15:0] divisor = 16'h0000;
  logic        signed_op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        busy;

  int checks = 0;
  int passed = 0;

  seq_divider_16 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .signed_op(signed_op),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  function automatic logic [15:0] mag(input logic [15:0] v, input logic s);
    return (s && v[15]) ? (16'h0000 - v) : v;
  endfunction

  // Drive one request, then count edges after the accept edge until out_valid.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          output int lat, output bit tmo);
    @(negedge clk);
    dividend = a; divisor = b; signed_op = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    tmo = !out_valid;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || quotient !== 16'h0000 ||
        remainder !== 16'h0000 || div_by_zero !== 1'b0)
      $display("FAIL reset_values: got rdy=%b vld=%b busy=%b q=%h r=%h dz=%b required 1 0 0 0000 0000 0",
               in_ready, out_valid, busy, quotient, remainder, div_by_zero);
    else passed++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL idle_after_reset: got rdy=%b busy=%b required 1 0", in_ready, busy);
    else passed++;
  endtask

  task automatic test_divide();
    logic [15:0] va [8] = '{16'd100, 16'hFF9C, 16'd100, 16'hFF9C, 16'hFF9C, 16'hFFFF, 16'h8000, 16'h8000};
    logic [15:0] vb [8] = '{16'd7,   16'd7,    16'hFFF9, 16'hFFF9, 16'd7,   16'h0001, 16'hFFFF, 16'hFFFF};
    logic        vs [8] = '{1'b0,    1'b1,     1'b1,     1'b1,     1'b0,    1'b0,     1'b1,     1'b0};
    logic [15:0] eq [8] = '{16'd14,  16'hFFF2, 16'hFFF2, 16'h000E, 16'h2484, 16'hFFFF, 16'h8000, 16'h0000};
    logic [15:0] er [8] = '{16'd2,   16'hFFFE, 16'h0002, 16'hFFFE, 16'h0000, 16'h0000, 16'h0000, 16'h8000};
    for (int i = 0; i < 8; i++) begin
      int lat, exp_lat;
      bit tmo;
      exp_lat = (EARLY && mag(va[i], vs[i]) < mag(vb[i], vs[i])) ? 0 : 16;
      start_op(va[i], vb[i], vs[i], lat, tmo);
      checks++;
      if (tmo) $display("FAIL div%0d_timeout: no out_valid within 40 cycles", i);
      else passed++;
      checks++;
      if (lat != exp_lat) $display("FAIL div%0d_latency: got %0d required %0d", i, lat, exp_lat);
      else passed++;
      checks++;
      if (quotient !== eq[i] || remainder !== er[i] || div_by_zero !== 1'b0)
        $display("FAIL div%0d_result: got q=%h r=%h dz=%b required q=%h r=%h dz=0",
                 i, quotient, remainder, div_by_zero, eq[i], er[i]);
      else passed++;
      release_result();
    end
  endtask

  task automatic test_div_by_zero();
    for (int m = 0; m < 2; m++) begin
      int lat;
      bit tmo;
      start_op(16'h1234, 16'h0000, m[0], lat, tmo);
      checks++;
      if (tmo || lat != 0) $display("FAIL dz%0d_latency: got %0d (timeout=%b) required 0 after accept", m, lat, tmo);
      else passed++;
      checks++;
      if (quotient !== 16'hFFFF || remainder !== 16'h1234 || div_by_zero !== 1'b1)
        $display("FAIL dz%0d_result: got q=%h r=%h dz=%b required q=ffff r=1234 dz=1", m, quotient, remainder, div_by_zero);
      else passed++;
      release_result();
      checks++;
      if (div_by_zero !== 1'b0 || out_valid !== 1'b0) $display("FAIL dz%0d_drop: got dz=%b vld=%b required 0 0", m, div_by_zero, out_valid);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit tmo;
    start_op(16'd1000, 16'd10, 1'b0, lat, tmo);
    checks++;
    if (tmo || quotient !== 16'd100 || remainder !== 16'd0) $display("FAIL bp_result: got q=%h r=%h required 0064 0000", quotient, remainder);
    else passed++;
    dividend = 16'd9; divisor = 16'd3; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || quotient !== 16'd100 || remainder !== 16'd0)
        $display("FAIL bp_hold%0d: got vld=%b rdy=%b busy=%b q=%h r=%h required 1 0 1 0064 0000",
                 c, out_valid, in_ready, busy, quotient, remainder);
      else passed++;
    end
    in_valid = 1'b0;
    release_result();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL bp_release: got rdy=%b vld=%b busy=%b required 1 0 0", in_ready, out_valid, busy);
    else passed++;
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    bit tmo;
    @(negedge clk);
    dividend = 16'd40000; divisor = 16'd7; signed_op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) $display("FAIL mid_calc: got busy=%b vld=%b required 1 0", busy, out_valid);
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || quotient !== 16'h0000 ||
        remainder !== 16'h0000 || div_by_zero !== 1'b0)
      $display("FAIL async_reset: got rdy=%b vld=%b busy=%b q=%h r=%h dz=%b required 1 0 0 0000 0000 0",
               in_ready, out_valid, busy, quotient, remainder, div_by_zero);
    else passed++;
    @(negedge clk); rst = 1'b0;
    start_op(16'd50000, 16'd3, 1'b0, lat, tmo);
    checks++;
    if (tmo || lat != 16 || quotient !== 16'd16666 || remainder !== 16'd2)
      $display("FAIL post_reset_div: got lat=%0d q=%0d r=%0d required 16 16666 2", lat, quotient, remainder);
    else passed++;
    release_result();
  endtask

  task automatic test_early_out();
    int lat, exp_lat;
    bit tmo;
    exp_lat = EARLY ? 0 : 16;
    start_op(16'd5, 16'd9, 1'b0, lat, tmo);
    checks++;
    if (tmo || lat != exp_lat) $display("FAIL early_latency: got %0d required %0d", lat, exp_lat);
    else passed++;
    checks++;
    if (quotient !== 16'd0 || remainder !== 16'd5 || div_by_zero !== 1'b0)
      $display("FAIL early_result: got q=%h r=%h dz=%b required 0000 0005 0", quotient, remainder, div_by_zero);
    else passed++;
    release_result();
  endtask

  initial begin
    test_reset();
    test_divide();
    test_div_by_zero();
    test_backpressure();
    test_reset_mid_calc();
    test_early_out();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
